// File: rtl/window_mac_pkg.sv
// rtl/window_mac_pkg.sv - shared constants, state encodings and helpers for window_mac
package window_mac_pkg;
  localparam int WORD_W          = 32;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int KERNEL_SIZE_DEF = 3;
  localparam int WINDOW_SIZE_DEF = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t relu_clamp(input word_t v, input logic en);
    return (en && v[WORD_W-1]) ? '0 : v;
  endfunction
endpackage

// File: rtl/window_mac_if.sv
// rtl/window_mac_if.sv - window input and result output handshake bundle
interface window_mac_if
  import window_mac_pkg::*;
#(
  parameter int WINDOW_SIZE = WINDOW_SIZE_DEF
);
  logic [WINDOW_SIZE*WORD_W-1:0] window;
  logic                          window_valid;
  logic                          window_finish;
  logic                          window_stall;
  logic                          result_valid;
  logic                          result_ready;
  word_t                         result_data;

  modport slave (
    input  window, window_valid, window_finish, result_ready,
    output window_stall, result_valid, result_data
  );

  modport master (
    output window, window_valid, window_finish, result_ready,
    input  window_stall, result_valid, result_data
  );
endinterface

// File: rtl/window_mac_result_fifo.sv
// rtl/window_mac_result_fifo.sv - result FIFO; head reads as zero while empty
module mac_result_fifo
  import window_mac_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  word_t                  push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output word_t                  head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/window_mac.sv
// rtl/window_mac.sv - two-stage multiply-accumulate over a KxK window with bias, ReLU
// and a credit-limited result FIFO
module window_mac
  import window_mac_pkg::*;
#(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int WINDOW_SIZE = KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           relu_en,
  input  word_t                          bias,
  input  logic                           weight_we,
  input  logic [$clog2(WINDOW_SIZE)-1:0] weight_idx,
  input  word_t                          weight_wdata,
  window_mac_if.slave                    bus,
  output logic                           busy,
  output logic                           done
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       state;
  word_t            weight  [WINDOW_SIZE];
  word_t            s1_prod [WINDOW_SIZE];
  logic             s1_valid;
  logic             s2_valid;
  word_t            s2_data;
  word_t            bias_r;
  logic             relu_r;
  word_t            sum;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] occupancy;
  logic             accept;
  logic             pop;
  logic             pipe_empty;

  // Every accepted window holds a FIFO slot until popped, so stalling on
  // occupancy (not on result_ready) makes overflow impossible.
  assign occupancy        = fifo_count + CNT_W'(s1_valid) + CNT_W'(s2_valid);
  assign bus.window_stall = (state != ST_RUN) || (occupancy >= CNT_W'(FIFO_DEPTH));
  assign accept           = bus.window_valid && !bus.window_stall;
  assign bus.result_valid = (fifo_count != '0);
  assign pop              = bus.result_valid && bus.result_ready;
  assign pipe_empty       = !s1_valid && !s2_valid && (fifo_count == '0);
  assign busy             = (state != ST_IDLE);
  assign done             = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      relu_r <= 1'b0;
      bias_r <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state  <= ST_RUN;
          relu_r <= relu_en;
          bias_r <= bias;
        end
        ST_RUN:   if (bus.window_finish && !accept) state <= ST_DRAIN;
        ST_DRAIN: if (pipe_empty) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // A write on the accepting edge lands after stage 1 has sampled the old weight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WINDOW_SIZE; k++) weight[k] <= '0;
    end else if (weight_we && (int'(weight_idx) < KERNEL_SIZE * KERNEL_SIZE)) begin
      weight[weight_idx] <= weight_wdata;
    end
  end

  always_comb begin
    sum = bias_r;
    for (int k = 0; k < WINDOW_SIZE; k++) sum = sum + s1_prod[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      for (int k = 0; k < WINDOW_SIZE; k++) s1_prod[k] <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) begin
        for (int k = 0; k < WINDOW_SIZE; k++)
          s1_prod[k] <= bus.window[k*WORD_W +: WORD_W] * weight[k];
      end
      if (s1_valid) s2_data <= relu_clamp(sum, relu_r);
    end
  end

  mac_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_valid),
    .push_data (s2_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (bus.result_data)
  );
endmodule

// File: doc/window_mac.md
WINDOW_MAC -- requirements
Module: window_mac

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, >= 2).
REQ-002 Parameter WINDOW_SIZE and KERNEL_SIZE, default `WINDOW_SIZE / `KERNEL_SIZE from CNNConfig.vh; window is KERNEL_SIZE x KERNEL_SIZE words.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse, begins an operation.
REQ-006 relu_en  in  1  clamp negative results to 0; sampled at start.
REQ-007 bias  in  32  signed bias; sampled at start.
REQ-008 weight_we  in  1  weight write strobe.
REQ-009 weight_idx  in  $clog2(WINDOW_SIZE)  weight index, row-major (row*KERNEL_SIZE+col).
REQ-010 weight_wdata  in  32  signed weight.
REQ-011 window  in  WINDOW_SIZE x 32  packed window from the window buffer, word k at [k*32 +: 32].
REQ-012 window_valid  in  1  window present.
REQ-013 window_finish  in  1  buffer has issued its last window (level).
REQ-014 window_stall  out  1  back-pressure to the window buffer.
REQ-015 result_valid  out  1  result FIFO non-empty.
REQ-016 result_ready  in  1  consumer accepts result.
REQ-017 result_data  out  32  FIFO head, signed.
REQ-018 busy  out  1  state != IDLE.
REQ-019 done  out  1  one-cycle pulse, operation complete.

Function
REQ-020 A window is accepted on any cycle with window_valid & ~window_stall & state RUN; window_valid held high across stalled cycles is not re-counted.
REQ-021 Stage 1 registers WINDOW_SIZE products window[k]*weight[k], each truncated to low 32 bits (two's complement wrap).
REQ-022 Stage 2 registers sum of all products plus bias, modulo 2^32; ReLU applied when relu_en sampled 1.
REQ-023 Stage 2 output written to FIFO on the following edge; result_valid rises 3 cycles after the accepting edge when FIFO was empty.
REQ-024 Results leave the FIFO in acceptance order; pop on result_valid & result_ready.
REQ-025 Credit = FIFO_DEPTH - fifo_count - in-flight (stages 1-2); window_stall = (credit == 0) | state != RUN; combinational from registers only, never from result_ready.
REQ-026 Simultaneous push and pop keep fifo_count unchanged; no overflow possible by REQ-025; pop on empty ignored.
REQ-027 States IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN when window_finish=1 and no accept this cycle; DRAIN->DONE when pipeline and FIFO empty; DONE->IDLE next cycle, done=1 in DONE only.
REQ-028 start outside IDLE is ignored.
REQ-029 weight_we honoured in any state; a write takes effect for windows accepted on later cycles; same-cycle write plus accept uses the old weight.
REQ-030 Weights persist across operations; not cleared by start.

Reset
REQ-031 On rst low: state IDLE, FIFO empty, pipeline valids 0, weights 0, window_stall 1, result_valid 0, busy 0, done 0, result_data 0.
REQ-032 Reset mid-operation discards in-flight and buffered results; no done pulse.

Structure
REQ-033 FSM encodings, FIFO_DEPTH default and word width 32 live in shared CNNConfig.vh.
REQ-034 Result FIFO is one sub-module, mac_result_fifo (push/pop/count/head).

Verification
REQ-035 KERNEL_SIZE=3, weights all 1, bias 0, window 1..9 -> result_data 45, result_valid 3 cycles after accept.
REQ-036 Same window, bias -50, relu_en=1 -> 0; relu_en=0 -> 0xFFFFFFFB (-5).
REQ-037 result_ready=0, 6 back-to-back windows -> exactly 4 accepted, window_stall high, released one cycle per pop, order preserved.
REQ-038 Weight 0x7FFFFFFF, window word 2 -> product wraps to 0xFFFFFFFE; sum modulo 2^32 checked.
REQ-039 window_finish after 5 windows, result_ready toggling -> done pulses once, after 5th result popped, busy falls next cycle.
REQ-040 rst low during RUN with 3 results queued -> result_valid 0 immediately, state IDLE, no done.
